// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller.
// Latches edge/level requests, masks them per line, picks the lowest-index
// enabled request and holds it in service until CPU ack followed by an EOI write.
// Optional macro IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer ahead of irq_q
// for lines driven from another clock domain.
module irq_ctrl #(
    parameter int WIDTH = 32,
    parameter int NIRQ  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic [NIRQ-1:0]  irq_in,
    output logic             irq_out,
    output logic [4:0]       irq_vec,
    input  logic             irq_ack
);

    typedef enum logic [2:0] {
        A_PEND = 3'd0,
        A_ENA  = 3'd1,
        A_MODE = 3'd2,
        A_SET  = 3'd3,
        A_STAT = 3'd4,
        A_EOI  = 3'd5
    } reg_addr_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [NIRQ-1:0] samp;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] ena;
    logic [NIRQ-1:0] mode;
    logic [NIRQ-1:0] edge_det;
    logic [NIRQ-1:0] req;
    logic [NIRQ-1:0] w1c;
    logic [NIRQ-1:0] setm;
    logic [NIRQ-1:0] ack_clr;
    logic [NIRQ-1:0] edge_next;
    logic            pend_any;
    logic [4:0]      winner;
    logic            found;
    logic            wr;
    logic            ack_take;
    logic            eoi;
    logic [WIDTH-1:0] rd;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NIRQ-1:0] sync1;
    logic [NIRQ-1:0] sync2;

    // Two-flop synchronizer for requests arriving from a foreign clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign samp = sync2;
`else
    assign samp = irq_in;
`endif

    assign wr       = cs & wen;
    assign eoi      = wr && (addr == A_EOI);
    assign w1c      = (wr && (addr == A_PEND)) ? din[NIRQ-1:0] : '0;
    assign setm     = (wr && (addr == A_SET))  ? din[NIRQ-1:0] : '0;
    assign ack_take = (state == IDLE) && irq_ack && irq_out;
    assign ack_clr  = ack_take ? (NIRQ'(1) << irq_vec) : '0;
    assign edge_det = samp & ~irq_q;
    // Clears first, then new edges and SET, so a coincident rise beats W1C/ack
    assign edge_next = (pending & ~w1c & ~ack_clr) | edge_det | setm;
    assign req      = pending & ena;
    assign pend_any = |req;

    // Previous-cycle sample used for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= samp;
        end
    end

    // Software-visible configuration: enable mask and edge/level mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ena  <= '0;
            mode <= '0;
        end else if (wr) begin
            if (addr == A_ENA)  ena  <= din[NIRQ-1:0];
            if (addr == A_MODE) mode <= din[NIRQ-1:0];
        end
    end

    // Pending latch: edge lines accumulate, level lines mirror the sampled input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (edge_next & mode) | (samp & ~mode);
        end
    end

    // Lowest-index enabled request wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (!found && req[i]) begin
                winner = 5'(i);
                found  = 1'b1;
            end
        end
    end

    // Request/in-service state machine with registered CPU-facing outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            irq_out <= 1'b0;
            irq_vec <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ack_take) begin
                        irq_out <= 1'b0;
                        state   <= BUSY;
                    end else begin
                        irq_out <= pend_any;
                        if (pend_any) irq_vec <= winner;
                    end
                end
                BUSY: begin
                    irq_out <= 1'b0;
                    if (eoi) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    irq_out <= 1'b0;
                end
            endcase
        end
    end

    // Register read mux; unused bits and unmapped addresses read zero
    always_comb begin
        rd = '0;
        case (addr)
            A_PEND: rd[NIRQ-1:0] = pending;
            A_ENA:  rd[NIRQ-1:0] = ena;
            A_MODE: rd[NIRQ-1:0] = mode;
            A_STAT: begin
                rd[8]   = (state == BUSY);
                rd[5]   = pend_any;
                rd[4:0] = irq_vec;
            end
            default: rd = '0;
        endcase
    end

    assign dout = rd;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed test-plan sequences plus randomized traffic, checked
// every cycle against a per-cycle behavioural model of the controller.
module tb_irq_ctrl;

    localparam int NIRQ  = 32;
    localparam int WIDTH = 32;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        wen = 1'b0;
    logic        irq_ack = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] din = '0;
    logic [31:0] irq_in = '0;
    logic [31:0] dout;
    logic        irq_out;
    logic [4:0]  irq_vec;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    // model state
    logic [31:0] m_pend, m_ena, m_mode, m_prev;
    logic [31:0] m_hist [0:1];
    bit          m_busy, m_out;
    logic [4:0]  m_vec;

    irq_ctrl #(.WIDTH(WIDTH), .NIRQ(NIRQ)) dut (
        .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr), .din(din),
        .dout(dout), .irq_in(irq_in), .irq_out(irq_out), .irq_vec(irq_vec),
        .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return m_pend;
            3'd1: return m_ena;
            3'd2: return m_mode;
            3'd4: return {23'b0, m_busy, 2'b00, |(m_pend & m_ena), m_vec};
            default: return 32'h0;
        endcase
    endfunction

    // behavioural model, one step per clock, reset is asynchronous
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = '0; m_ena = '0; m_mode = '0; m_prev = '0;
            m_hist[0] = '0; m_hist[1] = '0;
            m_busy = 1'b0; m_out = 1'b0; m_vec = '0;
        end else begin
            logic [31:0] s, np, req;
            int w;
            bit any, wrt, take;
            s    = (DLY == 0) ? irq_in : m_hist[1];
            req  = m_pend & m_ena;
            any  = (req != 0);
            w    = 0;
            for (int i = 31; i >= 0; i--) if (req[i]) w = i;
            wrt  = cs && wen;
            take = !m_busy && irq_ack && m_out;
            for (int i = 0; i < 32; i++) begin
                if (m_mode[i]) begin
                    np[i] = m_pend[i];
                    if (wrt && addr == 3'd0 && din[i]) np[i] = 1'b0;
                    if (take && i == int'(m_vec)) np[i] = 1'b0;
                    if (s[i] && !m_prev[i]) np[i] = 1'b1;
                    if (wrt && addr == 3'd3 && din[i]) np[i] = 1'b1;
                end else begin
                    np[i] = s[i];
                end
            end
            if (!m_busy) begin
                if (take) begin
                    m_busy = 1'b1;
                    m_out  = 1'b0;
                end else begin
                    m_out = any;
                    if (any) m_vec = 5'(w);
                end
            end else begin
                m_out = 1'b0;
                if (wrt && addr == 3'd5) m_busy = 1'b0;
            end
            if (wrt && addr == 3'd1) m_ena  = din;
            if (wrt && addr == 3'd2) m_mode = din;
            m_pend    = np;
            m_prev    = s;
            m_hist[1] = m_hist[0];
            m_hist[0] = irq_in;
        end
    end

    // per-cycle compare against the model
    always @(posedge clk) begin
        #1;
        if (checking) begin
            check("cyc_irq_out", {31'b0, irq_out}, {31'b0, m_out});
            check("cyc_irq_vec", {27'b0, irq_vec}, {27'b0, m_vec});
            check("cyc_dout", dout, m_read(addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wen = 1'b1; addr = a; din = d;
        tick();
        cs = 1'b0; wen = 1'b0; din = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        check(name, dout, exp);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        checking = 1'b1;

        // reset values
        check("rst_irq_out", {31'b0, irq_out}, 32'h0);
        check("rst_irq_vec", {27'b0, irq_vec}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 32'h0, "rst_read");
            tick();
        end

        // single edge line 0
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h1);
        irq_in = 32'h1;
        tick();
        irq_in = 32'h0;
        repeat (DLY) tick();
        rd(3'd0, 32'h1, "edge0_pend");
        check("edge0_out_early", {31'b0, irq_out}, 32'h0);
        tick();
        check("edge0_out", {31'b0, irq_out}, 32'h1);
        check("edge0_vec", {27'b0, irq_vec}, 32'h0);
        pulse_ack();
        check("ack0_out", {31'b0, irq_out}, 32'h0);
        rd(3'd0, 32'h0, "ack0_pend");
        tick();
        rd(3'd4, 32'h100, "ack0_stat");
        wr(3'd5, 32'h0);
        rd(3'd4, 32'h0, "eoi0_stat");

        // priority between lines 2 and 4
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd1, 32'h0000_0014);
        irq_in = 32'h14;
        tick();
        irq_in = 32'h0;
        repeat (DLY) tick();
        tick();
        check("prio_out", {31'b0, irq_out}, 32'h1);
        check("prio_vec2", {27'b0, irq_vec}, 32'h2);
        pulse_ack();
        rd(3'd0, 32'h10, "prio_pend_after_ack");
        wr(3'd5, 32'h0);
        check("prio_out_eoi", {31'b0, irq_out}, 32'h0);
        tick();
        check("prio_out_again", {31'b0, irq_out}, 32'h1);
        check("prio_vec4", {27'b0, irq_vec}, 32'h4);
        pulse_ack();
        wr(3'd5, 32'h0);

        // level line 3
        wr(3'd2, 32'h0);
        wr(3'd1, 32'h8);
        irq_in = 32'h8;
        repeat (2 + DLY) tick();
        check("lvl_out", {31'b0, irq_out}, 32'h1);
        check("lvl_vec", {27'b0, irq_vec}, 32'h3);
        wr(3'd0, 32'h8);
        rd(3'd0, 32'h8, "lvl_w1c_ignored");
        irq_in = 32'h0;
        repeat (DLY) tick();
        tick();
        rd(3'd0, 32'h0, "lvl_drop_pend");
        check("lvl_out_hold", {31'b0, irq_out}, 32'h1);
        tick();
        check("lvl_out_drop", {31'b0, irq_out}, 32'h0);

        // edge line 1: W1C versus coincident rise, then SET
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h2);
        irq_in = 32'h2;
        wr(3'd0, 32'h2);
        repeat (DLY) tick();
        rd(3'd0, 32'h2, "w1c_vs_edge");
        check("model_pin_pend", m_pend, 32'h2);
        wr(3'd0, 32'h2);
        rd(3'd0, 32'h0, "w1c_clear");
        irq_in = 32'h0;
        repeat (DLY + 1) tick();
        wr(3'd3, 32'h2);
        rd(3'd0, 32'h2, "set_pend");
        tick();
        rd(3'd3, 32'h0, "set_reads0");

        // ack ignored while busy, then reset mid-BUSY
        wr(3'd1, 32'h2);
        tick();
        check("busy_out", {31'b0, irq_out}, 32'h1);
        check("busy_vec", {27'b0, irq_vec}, 32'h1);
        pulse_ack();
        rd(3'd4, 32'h101, "busy_stat");
        check("model_pin_busy", {31'b0, m_busy}, 32'h1);
        pulse_ack();
        rd(3'd4, 32'h101, "busy_ack_ignored");
        check("busy_ack_out", {31'b0, irq_out}, 32'h0);
        reset = 1'b0;
        #1;
        check("rst2_out", {31'b0, irq_out}, 32'h0);
        rd(3'd4, 32'h0, "rst2_stat");
        rd(3'd1, 32'h0, "rst2_ena");
        rd(3'd2, 32'h0, "rst2_mode");
        tick();
        reset = 1'b1;
        tick();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 2) == 0)
                irq_in = irq_in ^ (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0)
                irq_in = irq_in ^ $urandom();
            cs      = ($urandom_range(0, 2) == 0);
            wen     = ($urandom_range(0, 1) == 0);
            addr    = 3'($urandom_range(0, 7));
            din     = ($urandom_range(0, 1) == 0) ? $urandom() : (32'h1 << $urandom_range(0, 31));
            irq_ack = ($urandom_range(0, 2) == 0);
            reset   = ($urandom_range(0, 599) != 0);
            tick();
        end
        cs = 1'b0; wen = 1'b0; irq_ack = 1'b0; reset = 1'b1;
        tick();
        tick();

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller that sits between the peripheral IRQ lines (timer irq and the rest of the `irqs` vector) and the CPU interrupt input.
- Latches edge- or level-type requests, masks them per line, and selects the highest-priority one (lowest index).
- Presents a request plus vector to the CPU and holds it in service until the CPU acknowledges and software writes end-of-interrupt (EOI).
- Sits on the memory bus as a slave, decoded like the timer (one 4 KB chip-select window).

Parameters:
- WIDTH, 32, bus data width; must be >= NIRQ.
- NIRQ, 32, number of interrupt input lines (1..32).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cs  input  1  chip select from address decoder
- wen  input  1  bus write enable
- addr  input  3  register select (bus_address[2:0])
- din  input  WIDTH  bus write data
- dout  output  WIDTH  bus read data (combinational from registers)
- irq_in  input  NIRQ  peripheral request lines, active-high
- irq_out  output  1  request to CPU, registered
- irq_vec  output  5  index of the line being requested / in service, registered
- irq_ack  input  1  CPU accept strobe, one clk wide

Behaviour:
- Reset: all registers, pending, in-service state, irq_out, irq_vec and sample flops go to 0. dout therefore reads 0 for every register.
- Register map (addr); unused bits read 0:
  - 0 PEND: R, pending[NIRQ-1:0]; W1C for edge lines only.
  - 1 ENA: R/W enable mask.
  - 2 MODE: R/W; 1 = edge (rising), 0 = level.
  - 3 SET: W; 1s set pending on edge lines. Reads 0.
  - 4 STAT: R, {busy at bit 8, 2'b0, pend_any at bit 5, irq_vec[4:0]}.
  - 5 EOI: W any value; clears busy.
  - 6, 7: reserved; read 0, writes ignored.
- Writes take effect only when cs & wen at a clk posedge.
- Sampling:
  - irq_q <= irq_in every cycle.
  - edge = irq_in & ~irq_q.
  - Edge line: pending set at the posedge after the rising cycle.
  - Level line: pending mirrors irq_q (1 cycle behind irq_in); W1C and SET have no effect on it.
- Priority: req = pending & ENA. Winner = lowest set index of req; pend_any = |req.
- States (2): IDLE, BUSY.
  - IDLE:
    - irq_out <= pend_any.
    - irq_vec <= winner (held at last value when pend_any = 0).
    - On irq_ack with irq_out = 1: capture irq_vec as in-service, clear that line's pending if it is an edge line, irq_out <= 0, go to BUSY.
  - BUSY:
    - irq_out held 0; irq_vec holds the in-service index.
    - New requests keep latching into pending.
    - EOI write returns to IDLE. irq_out may re-assert on the next cycle.
- Latency: irq_in rise on an enabled edge line gives pending at +1 clk and irq_out at +2 clk.
- Boundary conditions:
  - irq_ack while irq_out = 0, or while in BUSY: ignored.
  - W1C and a new edge on the same line in the same cycle: set wins; pending stays 1.
  - SET and W1C cannot coincide (different addresses).
  - irq_ack and EOI in the same cycle while in IDLE: ack processed, EOI ignored, state = BUSY.
  - ENA cleared while irq_out = 1 and before ack: irq_out follows pend_any on the next cycle. An ack arriving on that cycle is still honoured for the registered irq_vec.
  - Line index >= NIRQ: bits read 0 and are ignored on write.
  - Asserting reset mid-BUSY aborts everything; all state returns to the reset values.

Optional Feature:
- IRQ_CTRL_SYNC_EN defined: irq_in passes through a 2-flop synchronizer before irq_q, for lines driven from the clk10m timer domain.
  - Edge latency becomes pending at +3 clk and irq_out at +4 clk.
  - Level latency grows by 2 clk.
- Not defined: irq_in is sampled directly, with the latencies stated above.

Test Plan:
- Reset then read all addresses -> dout = 0. irq_out = 0, irq_vec = 0.
- ENA = 0x1, MODE = 0x1, pulse irq_in[0] for one cycle -> PEND = 0x1 at +1, irq_out = 1 and irq_vec = 0 at +2. irq_ack -> irq_out = 0, PEND = 0, STAT bit 8 = 1. EOI write -> STAT = 0.
- MODE = 0xFFFF_FFFF, ENA = 0x0000_0014, pulse irq_in[4] and irq_in[2] together -> irq_vec = 2. After ack + EOI -> irq_vec = 4, irq_out = 1 again.
- MODE = 0, ENA = 0x8, hold irq_in[3] = 1 -> irq_out = 1. Write PEND = 0x8 -> PEND stays 0x8. Drop irq_in[3] before ack -> PEND = 0 next cycle, irq_out = 0 the cycle after.
- Edge line 1: write PEND = 0x2 in the same cycle as an irq_in[1] rise -> PEND bit 1 = 1. Write SET = 0x2 on an idle line -> PEND = 0x2.
- While in BUSY, pulse irq_ack -> no change. Assert reset -> irq_out = 0, STAT = 0, all registers = 0.
